risc5_if_stage: RTL
===================

// Module: risc5_if_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register of the Risc5CPU pipeline.
//   - Holds the PC and drives the instruction-memory word address.
//   - Registers the fetched instruction into IF/ID for the decode stage.
//   - Honours the decode-stage Stall and the EX-resolved JumpFlag redirect.
//   - Keeps fetch and flush performance counters for the CPU test bench.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_INSTR 32'h0000_0013  bubble instruction (addi x0,x0,0) injected on flush/reset
//   IMEM_AW   8              instruction-memory word-address width
// PORTS
//   clk             in   1        rising-edge clock
//   reset           in   1        asynchronous, active-high reset
//   Stall           in   1        load-use stall from hazard unit; freeze PC and IF/ID
//   JumpFlag        in   2        00 none, 01 branch/JAL taken, 10 JALR, 11 treated as JALR
//   BranchAddr      in   32       target for JumpFlag=01
//   JalrAddr        in   32       target for JumpFlag=10/11
//   imem_addr       out  IMEM_AW  word address to async instruction ROM = PC[IMEM_AW+1:2]
//   imem_dout       in   32       instruction word returned combinationally by ROM
//   PC              out  32       current fetch PC
//   PC_id           out  32       PC of instruction held in IF/ID
//   Instruction_id  out  32       instruction held in IF/ID
//   Valid_id        out  1        IF/ID holds a real (non-bubble) instruction
//   FetchCount      out  32       instructions accepted into IF/ID since reset
//   FlushCount      out  32       redirects (flushes) since reset
// BEHAVIOUR
//   Reset (async, immediate, any time incl. mid-operation):
//   - PC=RESET_PC, PC_id=0, Instruction_id=NOP_INSTR, Valid_id=0, both counters=0.
//   - While reset is high, no state advances.
//   Per rising edge, priority JumpFlag > Stall > normal:
//   - Redirect (JumpFlag!=00):
//     - PC <= target, where target = BranchAddr (01) or JalrAddr (1x), with bits [1:0] forced 00.
//     - IF/ID <= {PC_id=0, Instruction_id=NOP_INSTR, Valid_id=0}; FlushCount++.
//     - Overrides Stall: the stalled instruction is on the wrong path.
//   - Stall (JumpFlag=00, Stall=1):
//     - PC, PC_id, Instruction_id, Valid_id and both counters hold.
//     - imem_addr stays stable.
//   - Normal:
//     - PC <= PC+4, wrapping 32'hFFFF_FFFC -> 0.
//     - IF/ID <= {PC, imem_dout, 1}; FetchCount++.
//   Timing:
//   - imem_addr is purely combinational from PC (truncation; no range check).
//   - Fetch latency: instruction at PC appears on Instruction_id one edge later.
//   - Redirect penalty: Valid_id=0 for exactly one cycle after a redirect edge. Target
//     instruction reaches IF/ID on the second edge after JumpFlag was sampled.
//   Counters:
//   - 32-bit, wrap modulo 2^32.
//   - The redirect edge itself does not increment FetchCount.
//   - Back-to-back redirects: each edge with JumpFlag!=00 reloads PC, re-inserts a bubble
//     and increments FlushCount.
//   Other rules:
//   - Stall deasserted with no redirect resumes from the held PC; no instruction is lost
//     or duplicated.
//   - No X propagation: all registers have reset values; outputs are registered
//     except imem_addr.
// TESTING
//   1 Reset 51 ns then free-run, ROM[i]=i, no Stall/Jump:
//     - PC 0,4,8,...; Instruction_id 0,1,2 on successive edges; Valid_id=1 from the first edge.
//     - FetchCount = number of edges.
//   2 Stall=1 for 2 cycles at PC=0x10:
//     - PC stays 0x10, Instruction_id stays ROM[3], FetchCount frozen.
//     - After release, next Instruction_id = ROM[4].
//   3 JumpFlag=01, BranchAddr=0x40 at PC=0x14:
//     - Next edge: PC=0x40, Instruction_id=0x00000013, Valid_id=0, FlushCount=1.
//     - Following edge: Instruction_id=ROM[16], PC_id=0x40.
//   4 JumpFlag=10, JalrAddr=0x23, with Stall=1 same cycle:
//     - Redirect wins: PC=0x20, bubble in IF/ID.
//   5 Assert reset asynchronously mid-cycle while PC=0x30:
//     - Outputs go to reset values before the next edge; counters=0.
//   6 Force PC near wrap (RESET_PC=32'hFFFF_FFF8):
//     - PC FFFF_FFF8 -> FFFF_FFFC -> 0000_0000.
//     - imem_addr follows the truncated PC bits.

Source files
------------

// File: rtl/risc5_if_stage.sv
// -----------------------------------------------------------------------------
// risc5_if_stage
//   Instruction-fetch stage and IF/ID pipeline register of the Risc5CPU.
//   The stage holds the fetch PC and drives the word address of an
//   asynchronous instruction ROM. It registers the returned word into IF/ID.
//   It also honours the hazard-unit stall and the EX-stage redirect, and it
//   keeps fetch and flush counters.
//
// Ports
//   clk            in   1        rising-edge clock
//   reset          in   1        asynchronous, active-high reset
//   Stall          in   1        freeze PC and IF/ID (load-use hazard)
//   JumpFlag       in   2        00 none, 01 branch/JAL, 1x JALR
//   BranchAddr     in   32       redirect target when JumpFlag = 01
//   JalrAddr       in   32       redirect target when JumpFlag = 1x
//   imem_addr      out  IMEM_AW  ROM word address = PC[IMEM_AW+1:2]
//   imem_dout      in   32       ROM data (combinational)
//   PC             out  32       current fetch PC
//   PC_id          out  32       PC of the instruction held in IF/ID
//   Instruction_id out  32       instruction held in IF/ID
//   Valid_id       out  1        IF/ID holds a real instruction (not a bubble)
//   FetchCount     out  32       instructions accepted into IF/ID
//   FlushCount     out  32       redirects taken
// -----------------------------------------------------------------------------
module risc5_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          IMEM_AW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic [1:0]         JumpFlag,
  input  logic [31:0]        BranchAddr,
  input  logic [31:0]        JalrAddr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        PC,
  output logic [31:0]        PC_id,
  output logic [31:0]        Instruction_id,
  output logic               Valid_id,
  output logic [31:0]        FetchCount,
  output logic [31:0]        FlushCount
);

  // Action taken on the next edge. A redirect beats a stall because the
  // stalled instruction is on the wrong path.
  typedef enum logic [1:0] {
    ACT_FETCH    = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } act_e;

  act_e        act;
  logic [31:0] target;

  logic [31:0] pc_q,       pc_d;
  logic [31:0] pc_id_q,    pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    if (JumpFlag != 2'b00) act = ACT_REDIRECT;
    else if (Stall)        act = ACT_STALL;
    else                   act = ACT_FETCH;
  end

  // JumpFlag = 11 is treated as JALR. Targets are always word aligned.
  assign target = {(JumpFlag[1] ? JalrAddr[31:2] : BranchAddr[31:2]), 2'b00};

  always_comb begin
    // NOTE: every signal starts at its held value so that no path through the
    // case can infer a latch.
    pc_d        = pc_q;
    pc_id_d     = pc_id_q;
    instr_id_d  = instr_id_q;
    valid_id_d  = valid_id_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (act)
      ACT_REDIRECT: begin
        pc_d        = target;
        pc_id_d     = 32'h0;
        instr_id_d  = NOP_INSTR;
        valid_id_d  = 1'b0;
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
      ACT_STALL: begin
        // Everything holds at its default.
      end
      default: begin
        // 32-bit addition wraps 0xFFFF_FFFC to 0 on its own.
        pc_d        = pc_q + 32'd4;
        pc_id_d     = pc_q;
        instr_id_d  = imem_dout;
        valid_id_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pc_id_q     <= 32'h0;
      instr_id_q  <= NOP_INSTR;
      valid_id_q  <= 1'b0;
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      pc_id_q     <= pc_id_d;
      instr_id_q  <= instr_id_d;
      valid_id_q  <= valid_id_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The ROM address is a plain truncation of the PC, with no range check.
  assign imem_addr      = pc_q[IMEM_AW+1:2];

  assign PC             = pc_q;
  assign PC_id          = pc_id_q;
  assign Instruction_id = instr_id_q;
  assign Valid_id       = valid_id_q;
  assign FetchCount     = fetch_cnt_q;
  assign FlushCount     = flush_cnt_q;

endmodule
